// File: rtl/seg14_scan_scheduler.sv
// rtl/seg14_scan_scheduler.sv - double-buffered multiplexed 14-segment display scan scheduler
module seg14_scan_scheduler #(
  parameter int NUM_DIGITS = 12,
  parameter int SEG_W      = 14,
  parameter int PRESCALE   = 4,
  parameter int BLANK_CYC  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [3:0]            wr_addr_i,
  input  logic [SEG_W-1:0]      wr_data_i,
  input  logic                  commit_i,
  output logic                  commit_done_o,
  output logic                  frame_start_o,
  output logic [NUM_DIGITS-1:0] sel_o,
  output logic [SEG_W-1:0]      segm_o
);

  localparam int MAX_CYC = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [3:0]    IDX_LAST   = 4'(NUM_DIGITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;
  localparam logic [1:0] S_DIGIT = (BLANK_CYC > 0) ? S_BLANK : S_DRIVE;
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pending_q, pending_d;
  logic [SEG_W-1:0]      shadow_q [NUM_DIGITS];
  logic [SEG_W-1:0]      active_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [SEG_W-1:0]      segm_q, segm_d;
  logic                  commit_done_q, frame_start_q, frame_start_d;
  logic                  boundary, swap, wr_en;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    boundary = (state_q == S_DRIVE) && (cnt_q == DRIVE_LAST) && (idx_q == IDX_LAST);
    if (!enable_i) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_DIGIT;
          idx_d   = '0;
          cnt_d   = '0;
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = S_DIGIT;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // Swap only between frames (or while dark) so a frame never mixes old and new data.
    swap      = pending_q && (boundary || (state_q == S_IDLE));
    pending_d = swap ? 1'b0 : (commit_i ? 1'b1 : pending_q);
    wr_en     = wr_valid_i && !pending_q && ({1'b0, wr_addr_i} < 5'(NUM_DIGITS));

    // Outputs are registered from the next state so they line up with the state register.
    sel_d         = '0;
    segm_d        = '0;
    frame_start_d = 1'b0;
    if (state_d == S_DRIVE) begin
      sel_d         = SEL_ONE << idx_d;
      segm_d        = swap ? shadow_q[idx_d] : active_q[idx_d];
      frame_start_d = (idx_d == 4'd0) && (cnt_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      sel_q         <= '0;
      segm_q        <= '0;
      commit_done_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      sel_q         <= sel_d;
      segm_q        <= segm_d;
      commit_done_q <= swap;
      frame_start_q <= frame_start_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        shadow_q[wr_addr_i] <= wr_data_i;
      end
      if (swap) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign wr_ready_o    = ~pending_q;
  assign commit_done_o = commit_done_q;
  assign frame_start_o = frame_start_q;
  assign sel_o         = sel_q;
  assign segm_o        = segm_q;

endmodule

// File: tb/tb_seg14_scan_scheduler.sv
// tb/tb_seg14_scan_scheduler.sv - scoreboard bench for seg14_scan_scheduler at default parameters
module tb_seg14_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, enable, wr_valid, wr_ready, commit, commit_done, frame_start;
  logic [3:0]  wr_addr;
  logic [13:0] wr_data, segm;
  logic [11:0] sel;

  always #5 clk = ~clk;

  seg14_scan_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .commit_i(commit), .commit_done_o(commit_done), .frame_start_o(frame_start),
    .sel_o(sel), .segm_o(segm)
  );

  typedef struct {
    logic [11:0] sel;
    logic [13:0] segm;
    logic        fs;
    logic        cd;
    logic        wrdy;
  } exp_t;

  exp_t        sb [$];
  logic [13:0] model [12];
  logic [13:0] letters [8];
  int          checks = 0;
  int          passed = 0;

  function automatic logic [28:0] pack(input exp_t e);
    return {e.sel, e.segm, e.fs, e.cd, e.wrdy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame at default timing: 1 blank cycle then 4 drive cycles per digit.
  task automatic push_frame(input logic cd_first);
    exp_t e;
    for (int d = 0; d < 12; d++) begin
      for (int c = 0; c < 5; c++) begin
        e.sel  = (c == 0) ? 12'd0 : (12'(1) << d);
        e.segm = (c == 0) ? 14'd0 : model[d];
        e.fs   = (d == 0) && (c == 1);
        e.cd   = cd_first && (d == 0) && (c == 0);
        e.wrdy = 1'b1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic hold_pending();
    foreach (sb[k]) sb[k].wrdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; wr_valid = 1'b0; wr_addr = 4'd0;
    wr_data = 14'd0; commit = 1'b0;
    for (int d = 0; d < 12; d++) model[d] = 14'd0;
    repeat (3) tick();
    checks++; if (sel !== 12'd0) $display("FAIL reset_sel got %h want 000", sel); else passed++;
    checks++; if (segm !== 14'd0) $display("FAIL reset_segm got %h want 0000", segm); else passed++;
    checks++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b want 1", wr_ready); else passed++;
    checks++; if (commit_done !== 1'b0) $display("FAIL reset_commit_done got %b want 0", commit_done); else passed++;
    checks++; if (frame_start !== 1'b0) $display("FAIL reset_frame_start got %b want 0", frame_start); else passed++;
  endtask

  task automatic test_scan();
    exp_t e;
    enable = 1'b1;
    rst_n  = 1'b1;
    push_frame(1'b0);
    push_frame(1'b0);
    for (int i = 0; i < 120; i++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if ({sel, segm, frame_start, commit_done, wr_ready} !== pack(e))
        $display("FAIL scan cyc %0d: got %h want %h (sel|segm|fs|cd|rdy)", i,
                 {sel, segm, frame_start, commit_done, wr_ready}, pack(e));
      else passed++;
    end
  endtask

  task automatic test_commit();
    exp_t e;
    push_frame(1'b0);
    for (int i = 0; i < 120; i++) begin
      if (i < 8) begin
        wr_valid = 1'b1; wr_addr = 4'(i); wr_data = letters[i];
      end
      commit = (i == 20);
      if (i == 20) begin
        hold_pending();
        for (int d = 0; d < 8; d++) model[d] = letters[d];
        push_frame(1'b1);
      end
      tick();
      wr_valid = 1'b0; commit = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({sel, segm, frame_start, commit_done, wr_ready} !== pack(e))
        $display("FAIL commit cyc %0d: got %h want %h (sel|segm|fs|cd|rdy)", i,
                 {sel, segm, frame_start, commit_done, wr_ready}, pack(e));
      else passed++;
      if (i == 61) begin
        checks++;
        if (segm !== 14'b01101100101000)
          $display("FAIL commit_digit0 got %b want 01101100101000", segm);
        else passed++;
      end
    end
  endtask

  task automatic test_pending_freeze();
    exp_t e;
    push_frame(1'b0);
    for (int i = 0; i < 60; i++) begin
      commit   = (i == 2) || (i == 10);
      wr_valid = (i >= 5); wr_addr = 4'd0; wr_data = 14'h3FFF;
      if (i == 2) begin
        hold_pending();
        push_frame(1'b1);
      end
      tick();
      commit = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({sel, segm, frame_start, commit_done, wr_ready} !== pack(e))
        $display("FAIL pending cyc %0d: got %h want %h (sel|segm|fs|cd|rdy)", i,
                 {sel, segm, frame_start, commit_done, wr_ready}, pack(e));
      else passed++;
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_bad_addr();
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      wr_valid = (i == 3); wr_addr = 4'd13; wr_data = 14'h3FFF;
      commit   = (i == 4);
      if (i == 4) begin
        hold_pending();
        push_frame(1'b1);
      end
      tick();
      wr_valid = 1'b0; commit = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({sel, segm, frame_start, commit_done, wr_ready} !== pack(e))
        $display("FAIL bad_addr cyc %0d: got %h want %h (sel|segm|fs|cd|rdy)", i,
                 {sel, segm, frame_start, commit_done, wr_ready}, pack(e));
      else passed++;
    end
  endtask

  // Enable drops in digit 5; while dark, a same-cycle write+commit swaps on the next cycle.
  task automatic test_enable_drop();
    exp_t e;
    for (int i = 0; i < 92; i++) begin
      if (i == 27) begin
        enable = 1'b0;
        sb.delete();
      end
      if (i >= 27 && i < 32) begin
        e.sel = 12'd0; e.segm = 14'd0; e.fs = 1'b0;
        e.cd  = (i == 30); e.wrdy = (i != 29);
        sb.push_back(e);
      end
      if (i == 29) begin
        wr_valid = 1'b1; wr_addr = 4'd1; wr_data = 14'h2AAA; commit = 1'b1;
        model[1] = 14'h2AAA;
      end
      if (i == 32) begin
        enable = 1'b1;
        push_frame(1'b0);
      end
      tick();
      wr_valid = 1'b0; commit = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({sel, segm, frame_start, commit_done, wr_ready} !== pack(e))
        $display("FAIL enable_drop cyc %0d: got %h want %h (sel|segm|fs|cd|rdy)", i,
                 {sel, segm, frame_start, commit_done, wr_ready}, pack(e));
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    push_frame(1'b0);
    for (int i = 0; i < 13; i++) begin
      commit = (i == 3);
      if (i == 3) hold_pending();
      tick();
      commit = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({sel, segm, frame_start, commit_done, wr_ready} !== pack(e))
        $display("FAIL pre_reset cyc %0d: got %h want %h (sel|segm|fs|cd|rdy)", i,
                 {sel, segm, frame_start, commit_done, wr_ready}, pack(e));
      else passed++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sel !== 12'd0) $display("FAIL async_reset_sel got %h want 000", sel); else passed++;
    checks++; if (segm !== 14'd0) $display("FAIL async_reset_segm got %h want 0000", segm); else passed++;
    checks++; if (wr_ready !== 1'b1) $display("FAIL async_reset_pending got wr_ready=%b want 1", wr_ready); else passed++;
    sb.delete();
    for (int d = 0; d < 12; d++) model[d] = 14'd0;
    tick();
    rst_n = 1'b1;
    push_frame(1'b0);
    for (int i = 0; i < 120; i++) begin
      commit = (i == 0);
      if (i == 0) begin
        hold_pending();
        push_frame(1'b1);
      end
      tick();
      commit = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({sel, segm, frame_start, commit_done, wr_ready} !== pack(e))
        $display("FAIL post_reset cyc %0d: got %h want %h (sel|segm|fs|cd|rdy)", i,
                 {sel, segm, frame_start, commit_done, wr_ready}, pack(e));
      else passed++;
    end
  endtask

  initial begin
    letters[0] = 14'h1B28; letters[1] = 14'h0877; letters[2] = 14'h2873; letters[3] = 14'h1201;
    letters[4] = 14'h1209; letters[5] = 14'h2136; letters[6] = 14'h0079; letters[7] = 14'h0C09;
    test_reset();
    test_scan();
    test_commit();
    test_pending_freeze();
    test_bad_addr();
    test_enable_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
